// File: rtl/rr_mux8_if.sv
// rr_mux8_if: eight-channel req/ack input bundle and valid/ready output bundle.
// The master modport is the requester/consumer side; slave is the rr_mux8 side.
interface rr_mux8_if #(
    parameter int WIDTH = 8
);
    logic [7:0]         in_req;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_ack;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_addr;

    modport master (
        output in_req,
        output in_data,
        output out_ready,
        input  in_ack,
        input  out_valid,
        input  out_data,
        input  out_addr
    );

    modport slave (
        input  in_req,
        input  in_data,
        input  out_ready,
        output in_ack,
        output out_valid,
        output out_data,
        output out_addr
    );
endinterface

// File: rtl/rr_mux8.sv
// rr_mux8: eight-channel round-robin multiplexer feeding a one-word registered output stage.
// Build option RR_MUX8_FIXED_PRIO_EN: lowest requesting index always wins, no rotating pointer.
module rr_mux8 #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    rr_mux8_if.slave bus
);
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [2:0]       out_addr_q;
    logic [2:0]       out_addr_d;
    logic [2:0]       idx_s;
    logic [2:0]       win_s;
    logic             found_s;
    logic             load_s;
    logic [7:0]       in_ack_s;
`ifndef RR_MUX8_FIXED_PRIO_EN
    logic [2:0]       ptr_q;
    logic [2:0]       ptr_d;
`endif

    // Grant search: first requester after the last winner, or lowest index in fixed mode.
    always_comb begin
        idx_s   = 3'd0;
        win_s   = 3'd0;
        found_s = 1'b0;
        for (int k = 0; k < 8; k++) begin
`ifdef RR_MUX8_FIXED_PRIO_EN
            idx_s = 3'(k);
`else
            idx_s = ptr_q + 3'(k + 1);
`endif
            if ((found_s == 1'b0) && (bus.in_req[idx_s] == 1'b1)) begin
                win_s   = idx_s;
                found_s = 1'b1;
            end else begin
                win_s   = win_s;
            end
        end
    end

    assign load_s = ((~out_valid_q) | bus.out_ready) & found_s;

    // Ack is purely a function of req, stage occupancy, ready and pointer; never of in_data.
    always_comb begin
        in_ack_s = 8'h00;
        if ((load_s == 1'b1) && (rst_n == 1'b1)) begin
            in_ack_s[win_s] = 1'b1;
        end else begin
            in_ack_s = 8'h00;
        end
    end

    // Output stage next state: load replaces, drain clears valid, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
`ifndef RR_MUX8_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        if (load_s == 1'b1) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[win_s*WIDTH +: WIDTH];
            out_addr_d  = win_s;
`ifndef RR_MUX8_FIXED_PRIO_EN
            ptr_d       = win_s;
`endif
        end else if ((out_valid_q == 1'b1) && (bus.out_ready == 1'b1)) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; ptr resets to 7 so channel 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= 3'd0;
`ifndef RR_MUX8_FIXED_PRIO_EN
            ptr_q       <= 3'd7;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
`ifndef RR_MUX8_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.in_ack    = in_ack_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
endmodule

// File: tb/tb_rr_mux8.sv
// tb_rr_mux8: directed scenarios for rr_mux8 with hand-computed expectations.
module tb_rr_mux8;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_mux8_if #(.WIDTH(8)) bus ();

    rr_mux8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_req = 8'h00;
        bus.in_data = 64'h0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ack !== 8'h00) begin errors++; $display("FAIL rst_ack: got %h exp 00", bus.in_ack); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", bus.out_valid); end
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d]: got %b exp 0", n, bus.out_valid); end
            checks++; if (bus.in_ack !== 8'h00) begin errors++; $display("FAIL idle_ack[%0d]: got %h exp 00", n, bus.in_ack); end
            checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL idle_data[%0d]: got %h exp 00", n, bus.out_data); end
            checks++; if (bus.out_addr !== 3'd0) begin errors++; $display("FAIL idle_addr[%0d]: got %0d exp 0", n, bus.out_addr); end
        end
        tick();
    endtask

    task automatic test_single();
        bus.in_data[5*8 +: 8] = 8'hA5;
        bus.in_req = 8'h20;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ack !== 8'h20) begin errors++; $display("FAIL single_ack: got %h exp 20", bus.in_ack); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h exp a5", bus.out_data); end
        checks++; if (bus.out_addr !== 3'd5) begin errors++; $display("FAIL single_addr: got %0d exp 5", bus.out_addr); end
        bus.in_req = 8'h00;
        @(negedge clk);
        checks++; if (bus.in_ack !== 8'h00) begin errors++; $display("FAIL single_ack_off: got %h exp 00", bus.in_ack); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL single_stale_data: got %h exp a5", bus.out_data); end
        checks++; if (bus.out_addr !== 3'd5) begin errors++; $display("FAIL single_stale_addr: got %0d exp 5", bus.out_addr); end
    endtask

    task automatic test_all_rr();
        logic [2:0] exp_addr;
        logic [7:0] exp_ack;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) bus.in_data[i*8 +: 8] = 8'h10 + 8'(i);
        bus.in_req = 8'hFF;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            exp_addr = 3'(n % 8);
            exp_ack = 8'h01 << exp_addr;
            @(negedge clk);
            checks++; if (bus.in_ack !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d]: got %h exp %h", n, bus.in_ack, exp_ack); end
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b exp 1", n, bus.out_valid); end
            checks++; if (bus.out_addr !== exp_addr) begin errors++; $display("FAIL rr_addr[%0d]: got %0d exp %0d", n, bus.out_addr, exp_addr); end
            checks++; if (bus.out_data !== (8'h10 + 8'(exp_addr))) begin errors++; $display("FAIL rr_data[%0d]: got %h exp %h", n, bus.out_data, 8'h10 + 8'(exp_addr)); end
        end
        bus.in_req = 8'h00;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_back_pressure();
        bus.in_data[2*8 +: 8] = 8'h22;
        bus.in_data[6*8 +: 8] = 8'h66;
        bus.in_req = 8'h44;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ack !== 8'h04) begin errors++; $display("FAIL bp_first_ack: got %h exp 04", bus.in_ack); end
        tick();
        bus.in_req = 8'h40;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++; if (bus.in_ack !== 8'h00) begin errors++; $display("FAIL bp_stall_ack[%0d]: got %h exp 00", n, bus.in_ack); end
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b exp 1", n, bus.out_valid); end
            checks++; if (bus.out_addr !== 3'd2) begin errors++; $display("FAIL bp_addr[%0d]: got %0d exp 2", n, bus.out_addr); end
            checks++; if (bus.out_data !== 8'h22) begin errors++; $display("FAIL bp_data[%0d]: got %h exp 22", n, bus.out_data); end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ack !== 8'h40) begin errors++; $display("FAIL bp_release_ack: got %h exp 40", bus.in_ack); end
        tick();
        checks++; if (bus.out_addr !== 3'd6) begin errors++; $display("FAIL bp_release_addr: got %0d exp 6", bus.out_addr); end
        checks++; if (bus.out_data !== 8'h66) begin errors++; $display("FAIL bp_release_data: got %h exp 66", bus.out_data); end
        bus.in_req = 8'h00;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.in_data[3*8 +: 8] = 8'h33;
        bus.in_req = 8'h08;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ack !== 8'h08) begin errors++; $display("FAIL mid_ack3: got %h exp 08", bus.in_ack); end
        tick();
        checks++; if (bus.out_addr !== 3'd3) begin errors++; $display("FAIL mid_full_addr: got %0d exp 3", bus.out_addr); end
        bus.in_req = 8'h00;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_addr !== 3'd0) begin errors++; $display("FAIL mid_async_addr: got %0d exp 0", bus.out_addr); end
        bus.in_data[0*8 +: 8] = 8'h0A;
        bus.in_req = 8'h09;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ack !== 8'h00) begin errors++; $display("FAIL mid_rst_ack: got %h exp 00", bus.in_ack); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_hold_valid: got %b exp 0", bus.out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ack !== 8'h01) begin errors++; $display("FAIL mid_post_ack0: got %h exp 01", bus.in_ack); end
        tick();
        checks++; if (bus.out_addr !== 3'd0) begin errors++; $display("FAIL mid_post_addr0: got %0d exp 0", bus.out_addr); end
        checks++; if (bus.out_data !== 8'h0A) begin errors++; $display("FAIL mid_post_data0: got %h exp 0a", bus.out_data); end
        bus.in_req = 8'h08;
        @(negedge clk);
        checks++; if (bus.in_ack !== 8'h08) begin errors++; $display("FAIL mid_post_ack3: got %h exp 08", bus.in_ack); end
        tick();
        checks++; if (bus.out_addr !== 3'd3) begin errors++; $display("FAIL mid_post_addr3: got %0d exp 3", bus.out_addr); end
        checks++; if (bus.out_data !== 8'h33) begin errors++; $display("FAIL mid_post_data3: got %h exp 33", bus.out_data); end
        bus.in_req = 8'h00;
        tick();
    endtask

`ifdef RR_MUX8_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.in_data[1*8 +: 8] = 8'h11;
        bus.in_data[4*8 +: 8] = 8'h44;
        bus.in_req = 8'h12;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            checks++; if (bus.in_ack !== 8'h02) begin errors++; $display("FAIL fp_ack[%0d]: got %h exp 02", n, bus.in_ack); end
            tick();
            checks++; if (bus.out_addr !== 3'd1) begin errors++; $display("FAIL fp_addr[%0d]: got %0d exp 1", n, bus.out_addr); end
            checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL fp_data[%0d]: got %h exp 11", n, bus.out_data); end
        end
        bus.in_req = 8'h00;
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_all_rr();
        test_back_pressure();
        test_reset_mid();
`ifdef RR_MUX8_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_mux8.md
# rr_mux8

Eight-channel round-robin multiplexer: the many-to-one counterpart of the 1-to-8 address-steered demultiplexer in the combinational library. Eight requesters each offer a WIDTH-bit word under a req/ack handshake; the block arbitrates fairly, captures the winner into a registered output stage, and presents it downstream with a 3-bit source address. A demultiplexer driven by `out_addr` can then route each word back to its channel.

## Interface
- `WIDTH`, default 8: data word width per channel.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_req`  in  8: per-channel request; bit i means `in_data` slice i is valid.
- `in_data`  in  8*WIDTH: channel i word at bits [i*WIDTH +: WIDTH].
- `in_ack`  out  8: combinational, one-hot or zero; bit i high means slice i is captured at this edge.
- `out_valid`  out  1: output register holds a word.
- `out_ready`  in  1: downstream accepts the word at this edge when `out_valid` is high.
- `out_data`  out  WIDTH: captured word.
- `out_addr`  out  3: index of the channel that supplied `out_data`.

## Operation
- Output stage has two states:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- Load condition: `load = (!out_valid | out_ready) & |in_req`.
- Grant search: scans channels `ptr+1, ptr+2, … ptr+8` (mod 8). The first channel with `in_req` high wins.
- On `load`:
  - `in_ack[win]` = 1 in the same cycle; all other `in_ack` bits = 0.
  - At the edge: `out_data` ← slice win, `out_addr` ← win, `out_valid` ← 1, `ptr` ← win.
- Drain without load (FULL, `out_ready` = 1, no req): `out_valid` ← 0. `out_data` and `out_addr` hold their stale values.
- Hold (FULL, `out_ready` = 0): `out_data`, `out_addr` and `out_valid` do not change, and `in_ack` = 0.
- Requester rules:
  - Hold `in_req` and the data slice stable until `in_ack` is seen.
  - After an ack, either drop `in_req` or present the next word the following cycle.
  - Dropping `in_req` before ack is legal. Nothing is captured for that channel.
- Reset values: `out_valid` = 0, `out_data` = 0, `out_addr` = 0, `ptr` = 7 (so channel 0 has first priority). `in_ack` = 0 while `rst_n` is low.
- Reset mid-operation discards any held word immediately. No ack is issued during reset.

## Timing
- Latency: 1 cycle. A req sampled with `load` = 1 gives `out_valid` = 1 on the next cycle.
- Throughput: one word per cycle when `out_ready` is held high.
- Simultaneous drain and load in FULL: allowed. The new word replaces the old one with no bubble.
- Fairness: with all 8 channels requesting continuously, each channel is granted exactly once in every 8 loads.
- `in_ack` is combinational from `in_req`, `out_valid`, `out_ready` and `ptr`. There is no combinational path from `in_data`.

## Configuration
- `RR_MUX8_FIXED_PRIO_EN`
  - Defined: fixed priority. The search always starts at channel 0 (lowest index wins), and `ptr` is not used.
  - Undefined (default): round robin as described above.
- All ports and timing are identical in both builds.

## Test plan
- Reset then idle: `in_req` = 0 for 10 cycles → `out_valid` = 0 and `in_ack` = 0 throughout; `out_data` = 0 and `out_addr` = 0.
- Single request: ch5 drives 0xA5, `out_ready` = 1 → `in_ack` = 0x20 in cycle 0; cycle 1 shows `out_valid` = 1, `out_data` = 0xA5, `out_addr` = 5; cycle 2 shows `out_valid` = 0.
- All 8 channels request continuously, each driving data equal to 0x10+i, `out_ready` = 1 → `out_addr` sequence 0,1,…,7,0 on consecutive cycles with no gaps, and each data value matches its channel.
- Backpressure: ch2 and ch6 request, `out_ready` = 0 for 4 cycles → word from ch2 is held stable and `in_ack` = 0 during the stall; on `out_ready` = 1, ch6 is acked in the same cycle and `out_addr` = 6 on the next cycle.
- Reset mid-stream: assert `rst_n` = 0 while FULL with `out_addr` = 3 → `out_valid` = 0 asynchronously; after release with ch0 and ch3 requesting, ch0 is granted first.
- With `RR_MUX8_FIXED_PRIO_EN` defined, ch1 and ch4 request continuously → ch1 is granted every cycle and ch4 is never acked.
